// File: rtl/led_strip_driver.sv
// -----------------------------------------------------------------------------
// led_strip_driver
//   WS2812-style single-wire LED strip transmitter. Requests colours from a
//   pattern generator one LED at a time, keeps one prefetched colour word in a
//   shadow buffer, and serializes each LED as GRB, MSB first, with per-bit
//   high/low timing. Each frame ends with a latch low period, then repeats.
//
// Ports
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   next_led_request  index of the LED whose colour is being requested
//   red_in/green_in/blue_in  colour channels from the pattern generator
//   color_valid       colours are valid for the current next_led_request
//   strip_data_out    serial line to the strip
//   frame_done        one-cycle pulse when the final bit of the frame completes
//   stalled           high while the shifter waits for a colour
// -----------------------------------------------------------------------------
module led_strip_driver #(
    parameter int unsigned NUM_LEDS     = 20,
    parameter int unsigned COLOR_WIDTH  = 8,
    parameter int unsigned T0H_CYCLES   = 40,
    parameter int unsigned T0L_CYCLES   = 85,
    parameter int unsigned T1H_CYCLES   = 80,
    parameter int unsigned T1L_CYCLES   = 45,
    parameter int unsigned RESET_CYCLES = 8000,
    localparam int unsigned CounterWidth = $clog2(NUM_LEDS)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    output logic [CounterWidth-1:0] next_led_request,
    input  logic [COLOR_WIDTH-1:0]  red_in,
    input  logic [COLOR_WIDTH-1:0]  green_in,
    input  logic [COLOR_WIDTH-1:0]  blue_in,
    input  logic                    color_valid,
    output logic                    strip_data_out,
    output logic                    frame_done,
    output logic                    stalled
);

    localparam int unsigned BitsPerLed  = 3 * COLOR_WIDTH;
    localparam int unsigned BitCntWidth = $clog2(BitsPerLed);

    // Phase counter covers the longest of the latch period and all bit phases.
    localparam int unsigned Max0      = (T0H_CYCLES > T0L_CYCLES) ? T0H_CYCLES : T0L_CYCLES;
    localparam int unsigned Max1      = (T1H_CYCLES > T1L_CYCLES) ? T1H_CYCLES : T1L_CYCLES;
    localparam int unsigned MaxBit    = (Max0 > Max1) ? Max0 : Max1;
    localparam int unsigned MaxCycles = (RESET_CYCLES > MaxBit) ? RESET_CYCLES : MaxBit;
    localparam int unsigned PhaseWidth = $clog2(MaxCycles + 1);

    // Terminal phase values. The *_EARLY values end the LOW of an LED's last
    // bit one cycle sooner so the LOAD cycle fits inside the bit period
    // (T0L/T1L must therefore be at least 2).
    localparam logic [PhaseWidth-1:0] ResetEnd = PhaseWidth'(RESET_CYCLES - 1);
    localparam logic [PhaseWidth-1:0] T0hEnd   = PhaseWidth'(T0H_CYCLES - 1);
    localparam logic [PhaseWidth-1:0] T1hEnd   = PhaseWidth'(T1H_CYCLES - 1);
    localparam logic [PhaseWidth-1:0] T0lEnd   = PhaseWidth'(T0L_CYCLES - 1);
    localparam logic [PhaseWidth-1:0] T1lEnd   = PhaseWidth'(T1L_CYCLES - 1);
    localparam logic [PhaseWidth-1:0] T0lEarly = PhaseWidth'(T0L_CYCLES - 2);
    localparam logic [PhaseWidth-1:0] T1lEarly = PhaseWidth'(T1L_CYCLES - 2);

    localparam logic [BitCntWidth-1:0]  LastBit = BitCntWidth'(BitsPerLed - 1);
    localparam logic [CounterWidth-1:0] LastLed = CounterWidth'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        ST_LATCH,
        ST_LOAD,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t                    state_q,     state_d;
    logic [PhaseWidth-1:0]     phase_q,     phase_d;
    logic [BitsPerLed-1:0]     shift_q,     shift_d;
    logic [BitCntWidth-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [CounterWidth-1:0]   led_cnt_q,   led_cnt_d;

    logic [BitsPerLed-1:0]     shadow_q,    shadow_d;
    logic                      full_q,      full_d;
    logic [CounterWidth-1:0]   req_q,       req_d;

    logic                      data_q,      data_d;
    logic                      frame_done_q, frame_done_d;
    logic                      stalled_q,   stalled_d;

    logic                      load;
    logic                      frame_end;
    logic                      cur_bit;
    logic [PhaseWidth-1:0]     high_end;
    logic [PhaseWidth-1:0]     low_end;
    logic [PhaseWidth-1:0]     low_end_early;

    // State and datapath registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_LATCH;
            phase_q      <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            led_cnt_q    <= '0;
            shadow_q     <= '0;
            full_q       <= 1'b0;
            req_q        <= '0;
            data_q       <= 1'b0;
            frame_done_q <= 1'b0;
            stalled_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            led_cnt_q    <= led_cnt_d;
            shadow_q     <= shadow_d;
            full_q       <= full_d;
            req_q        <= req_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            stalled_q    <= stalled_d;
        end
    end

    // Bit timing FSM.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        led_cnt_d = led_cnt_q;
        load      = 1'b0;
        frame_end = 1'b0;

        cur_bit       = shift_q[BitsPerLed-1];
        high_end      = cur_bit ? T1hEnd   : T0hEnd;
        low_end       = cur_bit ? T1lEnd   : T0lEnd;
        low_end_early = cur_bit ? T1lEarly : T0lEarly;

        unique case (state_q)
            ST_LATCH: begin
                if (phase_q == ResetEnd) begin
                    state_d = ST_LOAD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PhaseWidth'(1);
                end
            end

            ST_LOAD: begin
                // Stay here (line low, stalled) until the shadow holds a word.
                if (full_q) begin
                    load      = 1'b1;
                    shift_d   = shadow_q;
                    bit_cnt_d = '0;
                    phase_d   = '0;
                    state_d   = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (phase_q == high_end) begin
                    state_d = ST_LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PhaseWidth'(1);
                end
            end

            ST_LOW: begin
                if (bit_cnt_q != LastBit) begin
                    if (phase_q == low_end) begin
                        shift_d   = {shift_q[BitsPerLed-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BitCntWidth'(1);
                        phase_d   = '0;
                        state_d   = ST_HIGH;
                    end else begin
                        phase_d = phase_q + PhaseWidth'(1);
                    end
                end else if (led_cnt_q != LastLed) begin
                    if (phase_q == low_end_early) begin
                        led_cnt_d = led_cnt_q + CounterWidth'(1);
                        phase_d   = '0;
                        state_d   = ST_LOAD;
                    end else begin
                        phase_d = phase_q + PhaseWidth'(1);
                    end
                end else begin
                    if (phase_q == low_end) begin
                        frame_end = 1'b1;
                        led_cnt_d = '0;
                        phase_d   = '0;
                        state_d   = ST_LATCH;
                    end else begin
                        phase_d = phase_q + PhaseWidth'(1);
                    end
                end
            end

            default: begin
                state_d = ST_LATCH;
                phase_d = '0;
            end
        endcase
    end

    // Shadow buffer and request index. Load only happens when full and
    // capture only when empty, so the two never coincide.
    always_comb begin
        shadow_d = shadow_q;
        full_d   = full_q;
        req_d    = req_q;

        if (load) begin
            full_d = 1'b0;
            req_d  = (req_q == LastLed) ? '0 : req_q + CounterWidth'(1);
        end else if (color_valid && !full_q) begin
            full_d   = 1'b1;
            shadow_d = {green_in, red_in, blue_in};
        end
    end

    // Outputs are registered from next-state values so they line up with the
    // state they describe.
    always_comb begin
        data_d       = (state_d == ST_HIGH);
        stalled_d    = (state_d == ST_LOAD) && !full_d;
        frame_done_d = frame_end;
    end

    assign next_led_request = req_q;
    assign strip_data_out   = data_q;
    assign frame_done       = frame_done_q;
    assign stalled          = stalled_q;

endmodule

// File: tb/tb_led_strip_driver.sv
// -----------------------------------------------------------------------------
// tb_led_strip_driver
//   Directed bench: a colour table with hand-computed GRB words drives a small
//   generator model; a line monitor measures every high/low run and the
//   results are compared against the table and the expected bit timing.
// -----------------------------------------------------------------------------
module tb_led_strip_driver;

    localparam int unsigned NLeds = 3;
    localparam int unsigned BitsPerFrame = 72;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [1:0] next_led_request;
    logic [7:0] red_in = '0;
    logic [7:0] green_in = '0;
    logic [7:0] blue_in = '0;
    logic       color_valid = 1'b0;
    logic       strip_data_out;
    logic       frame_done;
    logic       stalled;

    led_strip_driver #(
        .NUM_LEDS     (3),
        .COLOR_WIDTH  (8),
        .T0H_CYCLES   (2),
        .T0L_CYCLES   (4),
        .T1H_CYCLES   (4),
        .T1L_CYCLES   (2),
        .RESET_CYCLES (10)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .next_led_request (next_led_request),
        .red_in           (red_in),
        .green_in         (green_in),
        .blue_in          (blue_in),
        .color_valid      (color_valid),
        .strip_data_out   (strip_data_out),
        .frame_done       (frame_done),
        .stalled          (stalled)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0]  g;
        logic [7:0]  r;
        logic [7:0]  b;
        logic [23:0] exp_grb;   // expected bit stream, first bit = bit 23
    } led_vec_t;

    led_vec_t vec [NLeds];

    int n_cmp = 0;
    int n_err = 0;

    // Generator controls
    bit withhold = 1'b0;    // hold color_valid low for LED1
    bit garble   = 1'b0;    // drive a bogus valid colour
    int gen_idx  = 0;

    // Monitor results
    int hi_q[$];
    int lo_q[$];
    int high_run = 0;
    int low_run  = 0;
    bit prev_d   = 1'b0;
    int fd_cnt   = 0;
    int st_cnt   = 0;

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Generator: answers one cycle after the request index changes.
    always @(negedge clk_in) begin
        if (int'(next_led_request) != gen_idx) begin
            gen_idx     = int'(next_led_request);
            color_valid = 1'b0;
        end else begin
            color_valid = !(withhold && gen_idx == 1);
        end
        if (gen_idx < int'(NLeds)) begin
            green_in = vec[gen_idx].g;
            red_in   = vec[gen_idx].r;
            blue_in  = vec[gen_idx].b;
        end
        if (garble) begin
            color_valid = 1'b1;
            green_in    = 8'h12;
            red_in      = 8'h34;
            blue_in     = 8'h56;
        end
    end

    // Line monitor: one hi_q entry per high pulse, lo_q gets the low run that
    // follows it once the next pulse starts.
    always @(negedge clk_in) begin
        if (strip_data_out && !prev_d) begin
            if (lo_q.size() < hi_q.size()) lo_q.push_back(low_run);
            high_run = 1;
        end else if (strip_data_out) begin
            high_run++;
        end else if (prev_d) begin
            hi_q.push_back(high_run);
            low_run = 1;
        end else begin
            low_run++;
        end
        prev_d = strip_data_out;
        if (frame_done) fd_cnt++;
        if (stalled) st_cnt++;
    end

    // Called on the tick that releases reset: that cycle is already latch
    // cycle 0, so 10 latch cycles + 1 LOAD cycle precede the first pulse.
    task automatic measure_restart(input string tag);
        int cnt;
        check({tag, "_line_low_at_release"}, int'(strip_data_out), 0);
        check({tag, "_req_zero_in_latch"}, int'(next_led_request), 0);
        cnt = 1;
        for (int i = 0; i < 40 && !strip_data_out; i++) begin
            tick();
            if (!strip_data_out) cnt++;
        end
        check({tag, "_first_pulse_seen"}, int'(strip_data_out), 1);
        check({tag, "_low_cycles_before_first_bit"}, cnt, 11);
        check({tag, "_req_after_first_load"}, int'(next_led_request), 1);
    endtask

    // Compare 24 monitored pulse widths against one LED's expected word.
    task automatic check_led(input int base, input int led, input string tag);
        int exp_w;
        for (int b = 0; b < 24; b++) begin
            exp_w = vec[led].exp_grb[23-b] ? 4 : 2;
            if (base + b < hi_q.size())
                check($sformatf("%s_led%0d_bit%0d_high", tag, led, b), hi_q[base+b], exp_w);
            else
                check($sformatf("%s_led%0d_bit%0d_missing", tag, led, b), hi_q.size(), base + b + 1);
        end
    endtask

    initial begin
        int st_before;
        int base;

        vec[0] = '{g: 8'hFF, r: 8'h00, b: 8'hAA, exp_grb: 24'hFF00AA};
        vec[1] = '{g: 8'h81, r: 8'h3C, b: 8'h00, exp_grb: 24'h813C00};
        vec[2] = '{g: 8'h00, r: 8'hFF, b: 8'h5A, exp_grb: 24'h00FF5A};

        // Reset state
        rst_in = 1'b1;
        repeat (3) tick();
        check("rst_strip_data", int'(strip_data_out), 0);
        check("rst_request", int'(next_led_request), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_stalled", int'(stalled), 0);

        // Frame 1: latch, then LED1 withheld to force a stall.
        withhold = 1'b1;
        rst_in   = 1'b0;
        measure_restart("start");

        for (int i = 0; i < 400 && !stalled; i++) tick();
        check("stall_seen", int'(stalled), 1);
        check("stall_bits_sent", hi_q.size(), 24);
        check("stall_req_held", int'(next_led_request), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("stall_line_low_c%0d", i), int'(strip_data_out), 0);
            check($sformatf("stall_flag_c%0d", i), int'(stalled), 1);
        end
        check("stall_no_extra_bits", hi_q.size(), 24);
        withhold = 1'b0;

        for (int i = 0; i < 1000 && fd_cnt < 1; i++) tick();
        check("frame1_done_count", fd_cnt, 1);
        check("frame1_bits", hi_q.size(), BitsPerFrame);
        check("frame1_req_in_latch", int'(next_led_request), 0);

        // Spurious valid while LED0 of the next frame sits in the full shadow.
        garble = 1'b1;
        tick();
        check("frame1_done_width", int'(frame_done), 0);
        repeat (4) tick();
        garble = 1'b0;
        st_before = st_cnt;

        // Frame 2: no stall, identical data.
        for (int i = 0; i < 1000 && fd_cnt < 2; i++) tick();
        check("frame2_done_count", fd_cnt, 2);
        check("frame2_bits", hi_q.size(), 2 * BitsPerFrame);
        check("frame2_no_stall", st_cnt - st_before, 0);

        for (int f = 0; f < 2; f++)
            for (int l = 0; l < int'(NLeds); l++)
                check_led(f * BitsPerFrame + l * 24, l, $sformatf("frame%0d", f + 1));

        // Bit periods: 6 cycles everywhere except after the stall and at the
        // frame end (last bit 0: 2 high + 4 low + 10 latch + 1 load = 17).
        for (int k = 0; k < 2 * int'(BitsPerFrame) - 1; k++) begin
            if (k == 23) continue;
            if (k == int'(BitsPerFrame) - 1)
                check("frame_end_period", hi_q[k] + lo_q[k], 17);
            else
                check($sformatf("period_bit%0d", k), hi_q[k] + lo_q[k], 6);
        end

        // Frame 3: reset during the high of LED1 bit 5.
        for (int i = 0; i < 1000 && !(hi_q.size() == 2 * int'(BitsPerFrame) + 29 && strip_data_out); i++)
            tick();
        check("midbit_reached", int'(hi_q.size() == 2 * int'(BitsPerFrame) + 29 && strip_data_out), 1);
        rst_in = 1'b1;
        tick();
        check("midrst_strip_data", int'(strip_data_out), 0);
        check("midrst_request", int'(next_led_request), 0);
        check("midrst_frame_done", int'(frame_done), 0);
        check("midrst_stalled", int'(stalled), 0);
        tick();
        rst_in = 1'b0;
        measure_restart("restart");
        base = hi_q.size();
        for (int i = 0; i < 400 && hi_q.size() < base + 24; i++) tick();
        check_led(base, 0, "restart");
        check("restart_no_frame_done", fd_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
